// File: rtl/mul_red_issue.sv
// Issues coefficient/twiddle reads to an external modular multiplier and buffers its results
// in a credit-controlled FIFO. Defining MUL_RED_ISSUE_CHECK_EN builds the sticky range checker.
module mul_red_issue #(
    parameter int unsigned MUL_LAT    = 5,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [1:0]        sel_a,
    input  logic [ADDR_W:0]   len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [23:0]       rd_coef,
    input  logic [23:0]       rd_tw,
    output logic [23:0]       mul_A,
    output logic [23:0]       mul_w,
    output logic              mul_Red_mode,
    output logic [1:0]        mul_sel_a,
    input  logic [23:0]       mul_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [23:0]       res_data,
    output logic [ADDR_W-1:0] res_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    // Wide enough for fifo count plus in-flight count (each at most FIFO_DEPTH).
    localparam int unsigned CNT_W = PTR_W + 2;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic              mode_q;
    logic [1:0]        sel_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   cnt_q;
    logic              rd_pend_q;
    logic [MUL_LAT:0]  tag_vld_q;
    logic [ADDR_W-1:0] tag_addr_q [MUL_LAT+1];
    logic [CNT_W-1:0]  inflight_q;
    logic [CNT_W-1:0]  fifo_cnt_q;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [23:0]       fifo_data_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];

    logic        accept, credit, last_issue, push, pop, fifo_empty;
    logic [23:0] push_data;

    assign accept     = (state_q == StIdle) && start;
    assign credit     = (fifo_cnt_q + inflight_q) < CNT_W'(FIFO_DEPTH);
    assign rd_en      = (state_q == StIssue) && credit;
    assign rd_addr    = rd_en ? cnt_q[ADDR_W-1:0] : '0;
    assign last_issue = rd_en && ((cnt_q + 1'b1) == len_q);

    assign mul_A        = rd_pend_q ? rd_coef : '0;
    assign mul_w        = rd_pend_q ? rd_tw : '0;
    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StDone);
    assign mul_Red_mode = busy & mode_q;
    assign mul_sel_a    = busy ? sel_q : '0;

    assign push       = tag_vld_q[MUL_LAT];
    assign push_data  = {mode_q ? 1'b0 : mul_result[23], mul_result[22:0]};
    assign fifo_empty = (fifo_cnt_q == '0);
    assign pop        = res_valid && res_ready;
    assign res_valid  = !fifo_empty;
    assign res_data   = fifo_empty ? '0 : fifo_data_q[rd_ptr_q];
    assign res_addr   = fifo_empty ? '0 : fifo_addr_q[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) state_d = (len == '0) ? StDone : StIssue;
            end
            StIssue: begin
                if (last_issue) state_d = StDrain;
            end
            StDrain: begin
                // Leave as the last entry is popped so done follows it by one cycle.
                if (inflight_q == '0 && (fifo_empty || (fifo_cnt_q == CNT_W'(1) && pop))) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            mode_q     <= 1'b0;
            sel_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            rd_pend_q  <= 1'b0;
            tag_vld_q  <= '0;
            inflight_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rd_en;
            tag_vld_q <= {tag_vld_q[MUL_LAT-1:0], rd_en};
            if (accept) begin
                mode_q <= mode;
                sel_q  <= sel_a;
                len_q  <= len;
                cnt_q  <= '0;
            end else if (rd_en) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (rd_en && !push) begin
                inflight_q <= inflight_q + 1'b1;
            end else if (push && !rd_en) begin
                inflight_q <= inflight_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        tag_addr_q[0] <= rd_addr;
        for (int i = 1; i <= int'(MUL_LAT); i++) begin
            tag_addr_q[i] <= tag_addr_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop) begin
                fifo_cnt_q <= fifo_cnt_q + 1'b1;
            end else if (pop && !push) begin
                fifo_cnt_q <= fifo_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= push_data;
            fifo_addr_q[wr_ptr_q] <= tag_addr_q[MUL_LAT];
        end
    end

`ifdef MUL_RED_ISSUE_CHECK_EN
    logic range_bad;
    logic err_q;

    always_comb begin
        range_bad = 1'b0;
        if (mode_q) begin
            range_bad = push_data >= 24'd8380417;
        end else begin
            range_bad = (push_data[11:0] >= 12'd3329) || (push_data[23:12] >= 12'd3329);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (push && range_bad) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mul_red_issue.sv
// Randomized scoreboard bench for mul_red_issue with a modular-add stand-in for the multiplier
// and a read-port memory model.
module tb_mul_red_issue;
    localparam int unsigned MUL_LAT    = 5;
    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int KQ = 3329;
    localparam int DQ = 8380417;
`ifdef MUL_RED_ISSUE_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic              clk, rst, start, mode;
    logic [1:0]        sel_a;
    logic [ADDR_W:0]   len;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [23:0]       rd_coef, rd_tw, mul_A, mul_w, mul_result;
    logic              mul_Red_mode;
    logic [1:0]        mul_sel_a;
    logic              res_valid, res_ready;
    logic [23:0]       res_data;
    logic [ADDR_W-1:0] res_addr;
    logic              busy, done, err;

    mul_red_issue #(
        .MUL_LAT   (MUL_LAT),
        .ADDR_W    (ADDR_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .sel_a       (sel_a),
        .len         (len),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_coef     (rd_coef),
        .rd_tw       (rd_tw),
        .mul_A       (mul_A),
        .mul_w       (mul_w),
        .mul_Red_mode(mul_Red_mode),
        .mul_sel_a   (mul_sel_a),
        .mul_result  (mul_result),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_addr    (res_addr),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rd_count = 0;
    int busy_cnt = 0;
    int last_pop = 0;
    int stall_cnt = 0;
    int cur_len = 0;
    bit mon_en = 0;
    bit rnd_ready = 0;
    bit bad_lane = 0;
    logic       cur_mode = 1'b0;
    logic [1:0] cur_sel = 2'b00;
    logic              rd_prev = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;

    logic [23:0] coef_mem [256];
    logic [23:0] tw_mem [256];
    logic [23:0] mpipe [MUL_LAT];
    logic [ADDR_W+23:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Stand-in multiplier: lane-wise add mod 3329 (Kyber) or add mod 8380417 (Dilithium).
    // In Dilithium mode bit 23 carries junk that the block must clear.
    function automatic logic [23:0] mul_model(input logic [23:0] a, input logic [23:0] w,
                                              input logic m, input logic junk, input bit bad);
        int lo, hi, v;
        if (!m) begin
            lo = (int'(a[11:0]) + int'(w[11:0])) % KQ;
            hi = (int'(a[23:12]) + int'(w[23:12])) % KQ;
            if (bad) lo = 'hD01;
            return {hi[11:0], lo[11:0]};
        end
        v = (int'(a[22:0]) + int'(w[22:0])) % DQ;
        return {junk, v[22:0]};
    endfunction

    assign mul_result = mpipe[MUL_LAT-1];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        mpipe[0] <= mul_model(mul_A, mul_w, mul_Red_mode, 1'($urandom), bad_lane);
        for (int i = 1; i < int'(MUL_LAT); i++) mpipe[i] <= mpipe[i-1];
        if (rd_en) begin
            rd_coef <= coef_mem[rd_addr];
            rd_tw   <= tw_mem[rd_addr];
        end else begin
            rd_coef <= 24'($urandom);
            rd_tw   <= 24'($urandom);
        end
        rd_prev   <= rd_en && !rst;
        prev_addr <= rd_addr;
        if (rst || (start && !busy)) rd_count <= 0;
        else if (rd_en) rd_count <= rd_count + 1;
    end

    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_cnt > 0) begin
                res_ready = 1'b0;
                stall_cnt--;
            end else if (rnd_ready) begin
                res_ready = 1'($urandom_range(0, 1));
            end else begin
                res_ready = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted result and checks the operand path.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (busy) busy_cnt++;
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) fail_now("unexpected_result");
                else check("result", {res_addr, res_data}, exp_q.pop_front());
                last_pop = cyc;
            end
            if (rd_en) begin
                check("rd_addr", rd_addr, rd_count[ADDR_W-1:0]);
                check("rd_within_len", rd_count < cur_len, 1);
            end
            check("mul_A", mul_A, rd_prev ? coef_mem[prev_addr] : 24'd0);
            check("mul_w", mul_w, rd_prev ? tw_mem[prev_addr] : 24'd0);
            check("mul_mode_sel", {mul_Red_mode, mul_sel_a}, busy ? {cur_mode, cur_sel} : 3'b000);
        end
    end

    task automatic fill(input logic m, input int l);
        logic [23:0] r;
        for (int a = 0; a < l; a++) begin
            if (!m) begin
                coef_mem[a] = {12'($urandom_range(0, KQ-1)), 12'($urandom_range(0, KQ-1))};
                tw_mem[a]   = {12'($urandom_range(0, KQ-1)), 12'($urandom_range(0, KQ-1))};
            end else begin
                coef_mem[a] = 24'($urandom_range(0, DQ-1));
                tw_mem[a]   = 24'($urandom_range(0, DQ-1));
            end
            r = mul_model(coef_mem[a], tw_mem[a], m, 1'b0, bad_lane);
            exp_q.push_back({8'(a), r});
        end
    endtask

    task automatic run(input logic m, input logic [1:0] s, input int l, input bit glitch,
                       input bit stall_chk);
        bit got;
        int done_cyc, start_cyc;
        fill(m, l);
        cur_mode = m;
        cur_sel  = s;
        cur_len  = l;
        busy_cnt = 0;
        mon_en   = 1;
        start    = 1'b1;
        mode     = m;
        sel_a    = s;
        len      = l[ADDR_W:0];
        start_cyc = cyc;
        done_cyc  = 0;
        got = 0;
        for (int i = 0; i < 5000 && !got; i++) begin
            @(negedge clk);
            if (i == 1) check("err_clear_on_start", err, 0);
            if (stall_chk && i == 15) check("reads_before_stall", rd_count, 4);
            if (done) begin
                got = 1;
                done_cyc = cyc;
            end
            @(posedge clk);
            #1;
            start = glitch && (i == 3);
            if (glitch && i == 3) begin
                mode  = ~m;
                sel_a = ~s;
            end
        end
        if (!got) fail_now("done_timeout");
        check("results_left", exp_q.size(), 0);
        check("reads_issued", rd_count, l);
        check("err_end", err, bad_lane ? CHK : 1'b0);
        if (l == 0) begin
            check("done_latency", done_cyc - start_cyc, 1);
            check("busy_cycles", busy_cnt, 1);
        end else begin
            check("done_after_pop", done_cyc - last_pop, 1);
        end
        @(negedge clk);
        check("done_pulse", {done, busy}, 2'b00);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_a"}, {rd_en, rd_addr, mul_A, mul_w, mul_Red_mode, mul_sel_a}, 0);
        check({name, "_b"}, {res_valid, res_data, res_addr, busy, done, err}, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        mode = 1'b0;
        sel_a = 2'b00;
        len = '0;
        for (int i = 0; i < int'(MUL_LAT); i++) mpipe[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_outputs");
        @(posedge clk);
        #1 rst = 1'b0;

        // Kyber, len 8, always ready
        run(1'b0, 2'b10, 8, 0, 0);

        // Dilithium, len 16, sink stalled for 20 cycles
        stall_cnt = 20;
        run(1'b1, 2'b11, 16, 0, 1);

        // Empty run
        run(1'b0, 2'b01, 0, 0, 0);

        // Reset in the middle of a run, then a clean rerun
        mon_en = 0;
        fill(1'b0, 8);
        start = 1'b1;
        mode = 1'b0;
        sel_a = 2'b10;
        len = 9'd8;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("mid_run_reset");
        exp_q.delete();
        run(1'b0, 2'b10, 8, 0, 0);

        // Out-of-range Kyber lane, sticky until the next start
        bad_lane = 1;
        run(1'b0, 2'b01, 4, 0, 0);
        bad_lane = 0;
        repeat (3) @(negedge clk);
        check("err_sticky", err, CHK);
        run(1'b0, 2'b01, 4, 0, 0);

        // Start with the other mode while running must be ignored
        rnd_ready = 1;
        run(1'b0, 2'b01, 16, 1, 0);

        // Full address range, then random runs with random backpressure
        run(1'b1, 2'b10, 256, 0, 0);
        for (int k = 0; k < 6; k++) begin
            run(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom_range(1, 40), 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
